key_debounce_multi: RTL and testbench



---
 rtl/key_debounce_multi.sv | 187 ++++++++++++++++++
 tb/tb_key_debounce_multi.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/key_debounce_multi.sv
// -----------------------------------------------------------------------------
// key_debounce_multi
//
// N-channel key front end. Each channel synchronises its raw pin, normalises
// polarity (1 = pressed), debounces, and produces press/release pulses plus
// long-press and auto-repeat pulses while the key stays held. All channels
// are independent copies of the same logic.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   key_in       raw asynchronous key pins (IDLE_LEVEL when released)
//   key_state    debounced level, 1 = pressed
//   key_press    1-cycle pulse when a press is accepted
//   key_release  1-cycle pulse when a release is accepted
//   key_long     1-cycle pulse when held LONG_CYCLES after the press
//   key_repeat   1-cycle pulse every REPEAT_CYCLES after key_long
//
// Timing: pin edge to key_state change is 2 + DEBOUNCE_CYCLES cycles; the
// press/release pulses appear in the same cycle key_state changes. All pulse
// outputs are registered.
//
// Per-channel hold FSM state lives in g_ch[i].hs_q (IDLE, HELD, REPEAT) and
// its timer in g_ch[i].ht_q, for hierarchical observation.
// -----------------------------------------------------------------------------
module key_debounce_multi #(
    parameter int                  NUM_KEYS        = 4,
    parameter logic [NUM_KEYS-1:0] IDLE_LEVEL      = {NUM_KEYS{1'b1}},
    parameter int                  DEBOUNCE_CYCLES = 1000000,
    parameter int                  LONG_CYCLES     = 50000000,
    parameter int                  REPEAT_CYCLES   = 10000000,
    parameter bit                  REPEAT_EN       = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat
);

    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int DW       = $clog2(DEBOUNCE_CYCLES);
    localparam int HW       = $clog2(HOLD_MAX) + 1;

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } hold_state_e;

    // Two-flop synchroniser. Both stages reset to the released pin level so a
    // reset never looks like a press.
    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;
    logic [NUM_KEYS-1:0] pressed;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = sync2_q ^ IDLE_LEVEL;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        logic [DW-1:0] cnt_q;
        logic [DW-1:0] cnt_d;
        logic          state_q;
        logic          state_d;
        logic          accept;
        logic          press_q;
        logic          press_d;
        logic          release_q;
        logic          release_d;
        logic          long_q;
        logic          long_d;
        logic          repeat_q;
        logic          repeat_d;
        hold_state_e   hs_q;
        hold_state_e   hs_d;
        logic [HW-1:0] ht_q;
        logic [HW-1:0] ht_d;

        // Debounce: count consecutive cycles the synchronised level disagrees
        // with the accepted level; any agreeing cycle restarts the count.
        always_comb begin
            cnt_d   = '0;
            state_d = state_q;
            accept  = 1'b0;
            if (pressed[i] != state_q) begin
                if (cnt_q == DB_LAST) begin
                    accept  = 1'b1;
                    state_d = pressed[i];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            press_d   = accept & state_d;
            release_d = accept & ~state_d;
        end

        // Hold FSM. In HELD/REPEAT the accepted level is "pressed", so any
        // accept there is a release; it is checked first so a release on the
        // terminal-count cycle suppresses the long/repeat pulse.
        always_comb begin
            hs_d     = hs_q;
            ht_d     = ht_q;
            long_d   = 1'b0;
            repeat_d = 1'b0;
            case (hs_q)
                ST_IDLE: begin
                    ht_d = '0;
                    if (press_d) begin
                        hs_d = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (accept) begin
                        hs_d = ST_IDLE;
                        ht_d = '0;
                    end else if (ht_q == LONG_LAST) begin
                        long_d = 1'b1;
                        ht_d   = '0;
                        hs_d   = ST_REPEAT;
                    end else begin
                        ht_d = ht_q + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (accept) begin
                        hs_d = ST_IDLE;
                        ht_d = '0;
                    end else if (ht_q == REP_LAST) begin
                        repeat_d = REPEAT_EN;
                        ht_d     = '0;
                    end else begin
                        ht_d = ht_q + 1'b1;
                    end
                end
                default: begin
                    hs_d = ST_IDLE;
                    ht_d = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q     <= '0;
                state_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
                hs_q      <= ST_IDLE;
                ht_q      <= '0;
            end else begin
                cnt_q     <= cnt_d;
                state_q   <= state_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
                repeat_q  <= repeat_d;
                hs_q      <= hs_d;
                ht_q      <= ht_d;
            end
        end

        assign key_state[i]   = state_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
        assign key_long[i]    = long_q;
        assign key_repeat[i]  = repeat_q;
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_key_debounce_multi
//
// Directed bench for key_debounce_multi with DEBOUNCE_CYCLES=4,
// LONG_CYCLES=10, REPEAT_CYCLES=5. Pins are driven inside a cycle (1 time
// unit after the rising edge); "cycle T" is the cycle in which a pin is
// changed, and after k calls to step() the bench sits in cycle T+k. Expected
// output vectors for every cycle are written out by hand per scenario.
// -----------------------------------------------------------------------------
module tb_key_debounce_multi;

    logic       clk;
    logic       rst;
    logic [3:0] key_in;
    logic [3:0] key_state;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;
    logic [3:0] key_repeat;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] exp_st;
    logic [3:0] exp_pr;
    logic [3:0] exp_rl;
    logic [3:0] exp_lg;
    logic [3:0] exp_rp;

    key_debounce_multi #(
        .NUM_KEYS        (4),
        .IDLE_LEVEL      (4'b1111),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (10),
        .REPEAT_CYCLES   (5),
        .REPEAT_EN       (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .key_repeat  (key_repeat)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] st, input logic [3:0] pr,
                                 input logic [3:0] rl, input logic [3:0] lg, input logic [3:0] rp);
        check({tag, ".state"},   32'(key_state),   32'(st));
        check({tag, ".press"},   32'(key_press),   32'(pr));
        check({tag, ".release"}, 32'(key_release), 32'(rl));
        check({tag, ".long"},    32'(key_long),    32'(lg));
        check({tag, ".repeat"},  32'(key_repeat),  32'(rp));
    endtask

    // Driver: advance one clock and settle away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- 1: reset, then idle with all pins released ----
        rst    = 1'b1;
        key_in = 4'b1111;
        step();
        step();
        step();
        check_outputs("t1_reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            check_outputs($sformatf("t1_idle_k%0d", k), 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        end

        // ---- 2: key 0 low for 8 cycles, short press ----
        key_in[0] = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            step();
            exp_st = (k >= 6 && k <= 13) ? 4'b0001 : 4'b0000;
            exp_pr = (k == 6)  ? 4'b0001 : 4'b0000;
            exp_rl = (k == 14) ? 4'b0001 : 4'b0000;
            check_outputs($sformatf("t2_k%0d", k), exp_st, exp_pr, exp_rl, 4'h0, 4'h0);
            if (k == 8) key_in[0] = 1'b1;
        end

        // ---- 3: key 1 bounce 3 low / 1 high / 3 low, never accepted ----
        key_in[1] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            check_outputs($sformatf("t3_k%0d", k), 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
            key_in[1] = (k <= 2 || (k >= 4 && k <= 6)) ? 1'b0 : 1'b1;
        end

        // ---- 4: key 2 held 40 cycles, long + repeats, release beats repeat ----
        key_in[2] = 1'b0;
        for (int k = 1; k <= 55; k++) begin
            step();
            exp_st = (k >= 6 && k <= 45) ? 4'b0100 : 4'b0000;
            exp_pr = (k == 6)  ? 4'b0100 : 4'b0000;
            exp_rl = (k == 46) ? 4'b0100 : 4'b0000;
            exp_lg = (k == 16) ? 4'b0100 : 4'b0000;
            exp_rp = (k == 21 || k == 26 || k == 31 || k == 36 || k == 41) ? 4'b0100 : 4'b0000;
            check_outputs($sformatf("t4_k%0d", k), exp_st, exp_pr, exp_rl, exp_lg, exp_rp);
            if (k == 40) key_in[2] = 1'b1;
        end

        // ---- 5: keys 0 and 3 together; release on the long terminal cycle ----
        key_in = 4'b0110;
        for (int k = 1; k <= 24; k++) begin
            step();
            exp_st = (k >= 6 && k <= 15) ? 4'b1001 : 4'b0000;
            exp_pr = (k == 6)  ? 4'b1001 : 4'b0000;
            exp_rl = (k == 16) ? 4'b1001 : 4'b0000;
            check_outputs($sformatf("t5_k%0d", k), exp_st, exp_pr, exp_rl, 4'h0, 4'h0);
            if (k == 10) key_in = 4'b1111;
        end

        // ---- 6: reset while key 2 held, re-accepted afterwards ----
        key_in[2] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            exp_st = ((k == 6) || (k >= 13 && k <= 25)) ? 4'b0100 : 4'b0000;
            exp_pr = (k == 6 || k == 13) ? 4'b0100 : 4'b0000;
            exp_rl = (k == 26) ? 4'b0100 : 4'b0000;
            exp_lg = (k == 23) ? 4'b0100 : 4'b0000;
            check_outputs($sformatf("t6_k%0d", k), exp_st, exp_pr, exp_rl, exp_lg, 4'h0);
            if (k == 6)  rst = 1'b1;
            if (k == 7)  rst = 1'b0;
            if (k == 20) key_in[2] = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
